// File: rtl/heap_array_reader.sv
// heap_array_reader
//
// Streams one array out of a heap memory. A request (start + array number)
// first reads the array length from a size table, then reads the array's
// heap words one at a time and presents each on a valid/ready output port.
//
// Handshake: an element transfers on a rising clock edge where outValid and
// outReady are both high. While outValid is high, outData and outLast stay
// stable until that edge. outValid never depends combinationally on
// outReady.
//
// Both memories have one cycle of read latency. sizeData must be valid in
// the cycle after sizeRead. heapData must be valid in the cycle after
// heapRead.
//
// Optional feature: define HEAP_READER_BOUNDS_CHECK_EN to enable bounds
// checking. In that build, a request with array >= NArrays or
// sizeData > NArea sets a sticky error and finishes without output. In the
// default build, error is tied low and the length is clamped to NArea.
//
// Ports
//   clock, reset             single clock; asynchronous active-high reset
//   start, array             request; sampled only when idle
//   sizeRead, sizeIndex      size-table read strobe and index
//   sizeData                 size-table read data
//   heapRead, heapAddr       heap read strobe and address (NArea*array + i)
//   heapData                 heap read data
//   outValid/outReady        element handshake
//   outData/outLast          element value and final-element flag
//   busy, done, error        status: not idle, one-cycle completion pulse,
//                            sticky bounds error
//   dbg_state                current FSM state
//   dbg_array_oob            captured array number is >= NArrays
module heap_array_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int NArrays            = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MemoryElementWidth-1:0] array,
  output logic                          sizeRead,
  output logic [MemoryElementWidth-1:0] sizeIndex,
  input  logic [MemoryElementWidth-1:0] sizeData,
  output logic                          heapRead,
  output logic [MemoryElementWidth-1:0] heapAddr,
  input  logic [MemoryElementWidth-1:0] heapData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [MemoryElementWidth-1:0] outData,
  output logic                          outLast,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [2:0]                    dbg_state,
  output logic                          dbg_array_oob
);

  localparam int W = MemoryElementWidth;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SIZE     = 3'd1;
  localparam logic [2:0] S_SIZEWAIT = 3'd2;
  localparam logic [2:0] S_READ     = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_PRESENT  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [W-1:0] NAREA_W   = W'(NArea);
  localparam logic [W-1:0] NARRAYS_W = W'(NArrays);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] array_q, array_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] len_q, len_d;
  logic [W-1:0] out_data_q, out_data_d;

  logic [W-1:0] i_next;
  logic         last_elem;

  assign i_next    = i_q + W'(1);
  assign last_elem = (i_next == len_q);

`ifdef HEAP_READER_BOUNDS_CHECK_EN
  logic error_q, error_d;
`else
  logic [W-1:0] size_clamped;
  assign size_clamped = (sizeData > NAREA_W) ? NAREA_W : sizeData;
`endif

  always_comb begin
    state_d    = state_q;
    array_d    = array_q;
    i_d        = i_q;
    len_d      = len_q;
    out_data_d = out_data_q;
`ifdef HEAP_READER_BOUNDS_CHECK_EN
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          array_d = array;
          i_d     = '0;
          state_d = S_SIZE;
        end
      end
      S_SIZE: state_d = S_SIZEWAIT;
      S_SIZEWAIT: begin
`ifdef HEAP_READER_BOUNDS_CHECK_EN
        if (dbg_array_oob || (sizeData > NAREA_W)) begin
          error_d = 1'b1;
          len_d   = '0;
          state_d = S_DONE;
        end else begin
          len_d   = sizeData;
          state_d = (sizeData == '0) ? S_DONE : S_READ;
        end
`else
        len_d   = size_clamped;
        state_d = (size_clamped == '0) ? S_DONE : S_READ;
`endif
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        out_data_d = heapData;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (outReady) begin
          i_d     = i_next;
          state_d = last_elem ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      array_q    <= '0;
      i_q        <= '0;
      len_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      array_q    <= array_d;
      i_q        <= i_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef HEAP_READER_BOUNDS_CHECK_EN
  // Sticky until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Strobes and status are decoded from the state register. As a result,
  // reset clears them at once, and sizeRead and heapRead are mutually
  // exclusive by construction.
  assign sizeRead      = (state_q == S_SIZE);
  assign heapRead      = (state_q == S_READ);
  assign outValid      = (state_q == S_PRESENT);
  assign outLast       = outValid && last_elem;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign outData       = out_data_q;
  assign sizeIndex     = array_q;
  // The address is computed at W bits, so it wraps on overflow.
  assign heapAddr      = NAREA_W * array_q + i_q;
  assign dbg_state     = state_q;
  assign dbg_array_oob = (array_q >= NARRAYS_W);

endmodule
